// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM scheduler: display fetches own even active-video cycles,
// the remaining cycles drain a small CPU write FIFO or run a full-screen clear.
module vga_fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  input  logic              valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [11:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              clear_req,
  input  logic [11:0]       clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       vga_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [11:0]       r_clr_color;
  logic [ADDR_W-1:0] r_faddr [FIFO_DEPTH];
  logic [11:0]       r_fdata [FIFO_DEPTH];
  logic [PW:0]       r_wptr, r_rptr;
  logic              r_err;
  logic [1:0]        r_vld_pipe;
  logic              r_disp_d1;
  logic [11:0]       r_pix;

  logic              w_empty, w_full, w_disp, w_pop, w_clr_wr;
  logic              w_accept, w_oor, w_push;
  logic [ADDR_W-1:0] w_vrow, w_disp_addr;

  // Extra pointer bit distinguishes full from empty.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  assign w_disp   = valid && !h_addr[0];
  assign w_pop    = !w_disp && !w_empty && (r_state == S_IDLE || r_state == S_DRAIN);
  assign w_clr_wr = !w_disp && (r_state == S_CLEAR);

  assign cpu_ready  = !w_full && (r_state == S_IDLE);
  assign w_accept   = cpu_we && cpu_ready;
  assign w_oor      = (cpu_addr >= NPIX);
  assign w_push     = w_accept && !w_oor;
  assign cpu_err    = r_err;
  assign clear_busy = (r_state != S_IDLE);

  // y*320 as shift-add; pixels are doubled so raster coords are halved.
  assign w_vrow      = ADDR_W'(v_addr[9:1]);
  assign w_disp_addr = (w_vrow << 8) + (w_vrow << 6) + ADDR_W'(h_addr[9:1]);

  // RAM port mux: display, then FIFO head, then clear counter.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_disp) begin
      mem_addr = w_disp_addr;
    end else if (w_pop) begin
      mem_we    = 1'b1;
      mem_addr  = r_faddr[r_rptr[PW-1:0]];
      mem_wdata = r_fdata[r_rptr[PW-1:0]];
    end else if (w_clr_wr) begin
      mem_we    = 1'b1;
      mem_addr  = r_clr_addr;
      mem_wdata = r_clr_color;
    end
  end

  // Clear sequencer: drain pending CPU writes, then sweep every pixel.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (clear_req) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty) begin
          r_state     <= S_CLEAR;
          r_clr_addr  <= '0;
          r_clr_color <= clear_color;
        end
        S_CLEAR: if (w_clr_wr) begin
          if (r_clr_addr == LAST) begin
            r_state    <= S_IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and the out-of-range error pulse.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_err <= w_accept && w_oor;
    end
  end

  // FIFO storage needs no reset; pointers guard it.
  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_faddr[r_wptr[PW-1:0]] <= cpu_addr;
      r_fdata[r_wptr[PW-1:0]] <= cpu_wdata;
    end
  end

  // Display pipe: RAM returns data one cycle late, latch it one more.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_disp_d1  <= 1'b0;
      r_pix      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], valid};
      r_disp_d1  <= w_disp;
      if (r_disp_d1) r_pix <= mem_rdata;
    end
  end

  assign vga_data = r_vld_pipe[1] ? r_pix : 12'h000;

endmodule
